// File: rtl/cal_seq_pkg.sv
// rtl/cal_seq_pkg.sv - shared types and constants for the calorie stream sequencer
package cal_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PARSE,
        EMIT,
        SETTLE,
        STORE,
        READ,
        WAIT_RES,
        DONE
    } state_e;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/calorie_stream_sequencer_ascii_dec_acc.sv
// rtl/calorie_stream_sequencer_ascii_dec_acc.sv - ASCII digit decode and decimal accumulator
module ascii_dec_acc
    import cal_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data,
    input  logic              load,
    input  logic              clear,
    output logic              is_digit,
    output logic [DATA_W-1:0] acc,
    output logic              ovf
);

    logic [3:0]        dig;
    logic [DATA_W+3:0] wide;

    assign is_digit = (data >= ASCII_0) && (data <= ASCII_9);
    assign dig      = data[3:0];

    // acc*10 as (acc<<3)+(acc<<1); four guard bits expose overflow
    assign wide = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{DATA_W{1'b0}}, dig};
    assign ovf  = |wide[DATA_W+3:DATA_W];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= wide[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/calorie_stream_sequencer.sv
// rtl/calorie_stream_sequencer.sv - parses decimal ASCII stream and sequences the top-three datapath
// Optional error detection enabled by defining CAL_SEQ_ERR_EN.
module calorie_stream_sequencer
    import cal_seq_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic              in_last,
    output logic [DATA_W-1:0] food_calories,
    output logic              food_vld,
    output logic              store_sum,
    output logic              read_max,
    input  logic              max_vld,
    output logic              done,
    output logic              busy,
    output logic [CNT_W-1:0]  items_cnt,
    output logic [CNT_W-1:0]  groups_cnt,
    output logic              parse_err
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e            state, state_nxt;
    logic [SC_W-1:0]   settle_cnt;
    logic              have_digit, have_group, eos, prev_strobe;
    logic              accept, in_is_digit, acc_ovf;
    logic [DATA_W-1:0] acc;

    assign in_rdy        = (state == IDLE) || (state == PARSE);
    assign accept        = in_vld && in_rdy;
    assign busy          = (state != IDLE) && (state != DONE);
    assign food_calories = food_vld ? acc : '0;

    ascii_dec_acc #(.DATA_W(DATA_W)) u_dec (
        .clk      (clk),
        .rst      (rst),
        .data     (in_data),
        .load     (accept && in_is_digit),
        .clear    (food_vld),
        .is_digit (in_is_digit),
        .acc      (acc),
        .ovf      (acc_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            have_digit  <= 1'b0;
            have_group  <= 1'b0;
            eos         <= 1'b0;
            prev_strobe <= 1'b0;
            items_cnt   <= '0;
            groups_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            prev_strobe <= food_vld || store_sum || read_max;
            settle_cnt  <= (state == SETTLE) ? settle_cnt + SC_W'(1) : '0;
            if (accept) begin
                if (state == IDLE) begin
                    items_cnt  <= '0;
                    groups_cnt <= '0;
                end
                if (in_is_digit) have_digit <= 1'b1;
                if (in_last)     eos        <= 1'b1;
            end
            if (food_vld) begin
                have_digit <= 1'b0;
                have_group <= 1'b1;
                items_cnt  <= items_cnt + CNT_W'(1);
            end
            if (store_sum) begin
                have_group <= 1'b0;
                groups_cnt <= groups_cnt + CNT_W'(1);
            end
            if (done) eos <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        food_vld  = 1'b0;
        store_sum = 1'b0;
        read_max  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, PARSE: begin
                if (accept) begin
                    state_nxt = PARSE;
                    // last byte flushes whatever is still open: item, then group, then result
                    if (in_last) begin
                        if (have_digit || in_is_digit) state_nxt = EMIT;
                        else if (have_group)           state_nxt = SETTLE;
                        else                           state_nxt = READ;
                    end else if (in_data == ASCII_LF) begin
                        if (have_digit)      state_nxt = EMIT;
                        else if (have_group) state_nxt = SETTLE;
                    end
                end
            end
            EMIT: begin
                food_vld  = 1'b1;
                state_nxt = eos ? SETTLE : PARSE;
            end
            SETTLE: begin
                if (settle_cnt == SC_W'(SETTLE_CYCLES - 1)) state_nxt = STORE;
            end
            STORE: begin
                store_sum = 1'b1;
                state_nxt = eos ? READ : PARSE;
            end
            READ: begin
                // hold off one cycle when a strobe just fired so pulses never abut
                if (!prev_strobe) begin
                    read_max  = 1'b1;
                    state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (max_vld) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CAL_SEQ_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((accept && !in_is_digit && in_data != ASCII_LF && in_data != ASCII_CR) ||
                     (accept && in_is_digit && acc_ovf) ||
                     (state == WAIT_RES && in_vld)) begin
            err_q <= 1'b1;
        end
    end
    assign parse_err = err_q;
`else
    logic unused_ovf;
    assign unused_ovf = acc_ovf;
    assign parse_err  = 1'b0;
`endif

endmodule

// File: tb/tb_calorie_stream_sequencer.sv
// tb/tb_calorie_stream_sequencer.sv - scoreboard bench for calorie_stream_sequencer
module tb_calorie_stream_sequencer;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int SETTLE = 2;

    localparam int EV_FOOD  = 0;
    localparam int EV_STORE = 1;
    localparam int EV_READ  = 2;
    localparam int EV_DONE  = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          items;
        int          groups;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_vld = 1'b0;
    logic              in_rdy;
    logic              in_last = 1'b0;
    logic [DATA_W-1:0] food_calories;
    logic              food_vld, store_sum, read_max;
    logic              max_vld = 1'b0;
    logic              done, busy, parse_err;
    logic [CNT_W-1:0]  items_cnt, groups_cnt;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  last_food_cyc = -100;
    int  done_cnt = 0;
    bit  prev_any = 1'b0;

    calorie_stream_sequencer #(
        .DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_last(in_last), .food_calories(food_calories), .food_vld(food_vld),
        .store_sum(store_sum), .read_max(read_max), .max_vld(max_vld), .done(done),
        .busy(busy), .items_cnt(items_cnt), .groups_cnt(groups_cnt), .parse_err(parse_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] val, input int it, input int gr);
        ev_t e;
        e.kind = kind; e.val = val; e.items = it; e.groups = gr;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d val %0d, expected nothing", kind, val);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || (kind == EV_FOOD && e.val != val)) begin
            errors++;
            $display("FAIL event_order: got kind %0d val %0d expected kind %0d val %0d",
                     kind, val, e.kind, e.val);
        end
        if (kind == EV_DONE) begin
            chk("done_items_cnt", 64'(items_cnt), 64'(e.items));
            chk("done_groups_cnt", 64'(groups_cnt), 64'(e.groups));
        end
    endtask

    // monitor: strobe ordering, exclusivity and settle spacing
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_any = 1'b0;
        end else begin
            if (food_vld || store_sum || read_max) begin
                chk("strobe_exclusive", 64'(int'(food_vld) + int'(store_sum) + int'(read_max)), 64'd1);
                chk("strobe_not_consecutive", 64'(prev_any), 64'd0);
            end
            if (food_vld) begin
                observe(EV_FOOD, food_calories);
                last_food_cyc = cyc;
            end
            if (store_sum) begin
                observe(EV_STORE, 32'd0);
                chk("settle_gap_ok", 64'(cyc - last_food_cyc >= SETTLE + 1), 64'd1);
            end
            if (read_max) observe(EV_READ, 32'd0);
            if (done) begin
                observe(EV_DONE, 32'd0);
                done_cnt++;
            end
            prev_any = food_vld || store_sum || read_max;
        end
    end

    // datapath stand-in: result two cycles after each request
    always @(negedge clk) begin
        if (!rst && read_max) begin
            @(posedge clk); @(posedge clk);
            #1 max_vld = 1'b1;
            @(posedge clk);
            #1 max_vld = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last);
        int t = 0;
        @(negedge clk);
        in_data = b; in_vld = 1'b1; in_last = last;
        while (!in_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            errors++;
            checks++;
            $display("FAIL in_rdy_timeout: in_rdy stayed %0d, expected 1", in_rdy);
        end
        @(posedge clk);
        #1 in_vld = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last_at_end);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], last_at_end && (i == s.len() - 1));
    endtask

    task automatic wait_done(input string name);
        int start = done_cnt;
        int t = 0;
        while (done_cnt == start && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_cnt == start) begin
            errors++;
            $display("FAIL %s_timeout: done count %0d, expected %0d", name, done_cnt, start + 1);
        end
        repeat (3) @(negedge clk);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_rdy", 64'(in_rdy), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_strobes", 64'({food_vld, store_sum, read_max, done}), 64'd0);
        chk("reset_counts", 64'({items_cnt, groups_cnt}), 64'd0);
        chk("reset_parse_err", 64'(parse_err), 64'd0);

        push(EV_FOOD, 32'd1000, 0, 0);
        push(EV_FOOD, 32'd2000, 0, 0);
        push(EV_STORE, 32'd0, 0, 0);
        push(EV_FOOD, 32'd3000, 0, 0);
        push(EV_STORE, 32'd0, 0, 0);
        push(EV_READ, 32'd0, 0, 0);
        push(EV_DONE, 32'd0, 3, 2);
        send_byte("1", 1'b0);
        @(negedge clk);
        chk("busy_after_first_byte", 64'(busy), 64'd1);
        send_str("000\n2000\n\n3000\n", 1'b1);
        wait_done("basic");
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("counts_held_after_done", 64'(items_cnt), 64'd3);

        push(EV_FOOD, 32'd5, 0, 0);
        push(EV_STORE, 32'd0, 0, 0);
        push(EV_FOOD, 32'd7, 0, 0);
        push(EV_STORE, 32'd0, 0, 0);
        push(EV_READ, 32'd0, 0, 0);
        push(EV_DONE, 32'd0, 2, 2);
        send_str("5\n\n\n\n7", 1'b1);
        wait_done("blank_lines");

        push(EV_FOOD, 32'd12, 0, 0);
        push(EV_FOOD, 32'd34, 0, 0);
        push(EV_STORE, 32'd0, 0, 0);
        push(EV_READ, 32'd0, 0, 0);
        push(EV_DONE, 32'd0, 2, 1);
        send_str("12\r\n34\r\n", 1'b1);
        wait_done("crlf");

        send_str("45", 1'b0);
        do_reset();
        @(negedge clk);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_in_rdy", 64'(in_rdy), 64'd1);
        push(EV_FOOD, 32'd9, 0, 0);
        push(EV_STORE, 32'd0, 0, 0);
        push(EV_READ, 32'd0, 0, 0);
        push(EV_DONE, 32'd0, 1, 1);
        send_str("9\n", 1'b1);
        wait_done("midreset");

        push(EV_READ, 32'd0, 0, 0);
        push(EV_DONE, 32'd0, 0, 0);
        send_str("\n", 1'b1);
        wait_done("empty_stream");

        push(EV_FOOD, 32'd12, 0, 0);
        push(EV_STORE, 32'd0, 0, 0);
        push(EV_READ, 32'd0, 0, 0);
        push(EV_DONE, 32'd0, 1, 1);
        send_str("1a2\n", 1'b1);
        wait_done("illegal_byte");
`ifdef CAL_SEQ_ERR_EN
        chk("parse_err_illegal", 64'(parse_err), 64'd1);
        do_reset();
        @(negedge clk);
        chk("parse_err_cleared", 64'(parse_err), 64'd0);
        push(EV_FOOD, 32'd0, 0, 0);
        push(EV_STORE, 32'd0, 0, 0);
        push(EV_READ, 32'd0, 0, 0);
        push(EV_DONE, 32'd0, 1, 1);
        send_str("4294967296\n", 1'b1);
        wait_done("overflow");
        chk("parse_err_overflow", 64'(parse_err), 64'd1);
`else
        chk("parse_err_tied_low", 64'(parse_err), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
